pixel_scheduler: RTL and testbench

//  Upstream/downstream sequencer for the mandelbrot renderer core. Walks a WIDTH x HEIGHT raster, issues one

---
 rtl/pixel_scheduler.sv | 171 +++++++++++++++++
 tb/tb_pixel_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_scheduler                                                          |
// | Raster walker that feeds pixels to the mandelbrot renderer and forwards  |
// | each iteration count to the frame buffer over a valid/ready write port.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_scheduler #(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 120,
  parameter int ITERATIONS   = 127,
  parameter int OUTPUT_WIDTH = 7,
  parameter int ADDR_WIDTH   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [14:0]      view_cx,
  input  logic signed [14:0]      view_cy,
  input  logic [2:0]              view_zoom,
  output logic                    r_start,
  output logic [7:0]              r_x,
  output logic [7:0]              r_y,
  output logic signed [14:0]      r_cx,
  output logic signed [14:0]      r_cy,
  output logic [2:0]              r_zoom,
  input  logic                    r_done,
  input  logic [OUTPUT_WIDTH-1:0] r_iters,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [OUTPUT_WIDTH-1:0] wr_data,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int                  DRAIN_W    = $clog2(ITERATIONS + 5);
  localparam logic [DRAIN_W-1:0]  DRAIN_INIT = DRAIN_W'(ITERATIONS + 4);
  localparam logic [7:0]          X_LAST     = 8'(WIDTH - 1);
  localparam logic [7:0]          Y_LAST     = 8'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [7:0]              x_q, x_d;
  logic [7:0]              y_q, y_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic signed [14:0]      cx_q, cx_d;
  logic signed [14:0]      cy_q, cy_d;
  logic [2:0]              zoom_q, zoom_d;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic                    frame_done_q, frame_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_DRAIN;
      drain_q      <= DRAIN_INIT;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      zoom_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      zoom_q       <= zoom_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    zoom_d       = zoom_q;
    data_d       = data_q;
    frame_done_d = 1'b0;

    case (state_q)
      // Let a renderer interrupted by reset run out before issuing new work.
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_IDLE: begin
        if (enable) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cx_d    = view_cx;
        cy_d    = view_cy;
        zoom_d  = view_zoom;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (r_done) begin
          data_d  = r_iters;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          if (x_q != X_LAST) begin
            x_d     = x_q + 8'd1;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_ISSUE;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + 8'd1;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_ISSUE;
          end else begin
            x_d          = '0;
            y_d          = '0;
            addr_d       = '0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_DRAIN;
      end
    endcase
  end

  assign r_start    = (state_q == S_ISSUE);
  assign wr_valid   = (state_q == S_WRITE);
  assign busy       = (state_q != S_IDLE);
  assign r_x        = x_q;
  assign r_y        = y_q;
  assign r_cx       = cx_q;
  assign r_cy       = cy_q;
  assign r_zoom     = zoom_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_scheduler                                                       |
// | Directed and randomized checks of pixel_scheduler on a 4x2 raster.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pixel_scheduler;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int ITER = 127;
  localparam int OW   = 7;
  localparam int AW   = 3;
  localparam int NPIX = W * H;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic signed [14:0] view_cx = '0;
  logic signed [14:0] view_cy = '0;
  logic [2:0]         view_zoom = '0;
  logic               r_start;
  logic [7:0]         r_x, r_y;
  logic signed [14:0] r_cx, r_cy;
  logic [2:0]         r_zoom;
  logic               r_done;
  logic [OW-1:0]      r_iters;
  logic               wr_valid, wr_ready;
  logic [AW-1:0]      wr_addr;
  logic [OW-1:0]      wr_data;
  logic               frame_done, busy;

  logic          rend_done = 1'b0;
  logic [OW-1:0] rend_iters = '0;
  logic          spur_done = 1'b0;
  logic [OW-1:0] spur_iters = '0;
  logic          rdy_dir = 1'b1, rdy_rand = 1'b0, rdy_r = 1'b1;

  assign r_done   = rend_done | spur_done;
  assign r_iters  = spur_done ? spur_iters : rend_iters;
  assign wr_ready = rdy_rand ? rdy_r : rdy_dir;

  int n_checks = 0, n_fail = 0;
  int lat_fixed = 3, seed = 0;
  int fd_count = 0, start_count = 0, frames = 0;
  int wlog_addr[$], wlog_data[$];
  int iss_cx[$], iss_cy[$], iss_zoom[$];
  int rx, ry, rlat;

  always #5 clk = ~clk;

  pixel_scheduler #(
    .WIDTH(W), .HEIGHT(H), .ITERATIONS(ITER), .OUTPUT_WIDTH(OW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .view_cx(view_cx), .view_cy(view_cy), .view_zoom(view_zoom),
    .r_start(r_start), .r_x(r_x), .r_y(r_y), .r_cx(r_cx), .r_cy(r_cy), .r_zoom(r_zoom),
    .r_done(r_done), .r_iters(r_iters),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .busy(busy)
  );

  // Reference renderer result for a pixel, parameterised by a per-frame seed.
  function automatic int model_iters(input int x, input int y, input int s);
    return (x + 4 * y + s) % 128;
  endfunction

  // Observe handshakes and pulses mid-cycle, where everything is settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) begin
        wlog_addr.push_back(int'(wr_addr));
        wlog_data.push_back(int'(wr_data));
      end
      if (frame_done) fd_count++;
      if (r_start) start_count++;
    end
  end

  // Renderer model: answers each start after a fixed or random latency.
  initial forever begin
    @(posedge clk); #1;
    if (r_start === 1'b1) begin
      rx   = int'(r_x);
      ry   = int'(r_y);
      rlat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
      iss_cx.push_back(int'(r_cx));
      iss_cy.push_back(int'(r_cy));
      iss_zoom.push_back(int'(r_zoom));
      repeat (rlat) @(posedge clk);
      #1;
      rend_done  = 1'b1;
      rend_iters = OW'(model_iters(rx, ry, seed));
      @(posedge clk); #1;
      rend_done  = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rdy_r = ($urandom_range(0, 2) != 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input int target, input int budget);
    int c;
    c = 0;
    while (fd_count < target && c < budget) begin
      tick(1);
      c++;
    end
    chk("frame_done_count", fd_count, target);
  endtask

  task automatic wait_start(input int budget);
    int c;
    c = 0;
    while (r_start !== 1'b1 && c < budget) begin
      tick(1);
      c++;
    end
    chk("r_start_seen", r_start, 1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c;
    c = 0;
    while (wlog_addr.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    chk("writes_reached", (wlog_addr.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic clear_logs();
    wlog_addr.delete();
    wlog_data.delete();
    iss_cx.delete();
    iss_cy.delete();
    iss_zoom.delete();
  endtask

  task automatic check_frame(input int s, input int ecx, input int ecy, input int ez);
    chk("wr_count", wlog_addr.size(), NPIX);
    chk("issue_count", iss_cx.size(), NPIX);
    for (int i = 0; i < NPIX; i++) begin
      if (i < wlog_addr.size()) begin
        chk($sformatf("wr_addr[%0d]", i), wlog_addr[i], i);
        chk($sformatf("wr_data[%0d]", i), wlog_data[i], model_iters(i % W, i / W, s));
      end
      if (i < iss_cx.size()) begin
        chk($sformatf("r_cx[%0d]", i), iss_cx[i], ecx);
        chk($sformatf("r_cy[%0d]", i), iss_cy[i], ecy);
        chk($sformatf("r_zoom[%0d]", i), iss_zoom[i], ez);
      end
    end
    clear_logs();
  endtask

  initial begin
    int c;
    int a, d, sc;
    logic signed [14:0] ecx, ecy;
    logic [2:0] ez;

    // Reset state
    tick(3);
    chk("rst_r_start", r_start, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_r_x", r_x, 0);
    chk("rst_r_cx", r_cx, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_busy_drain", busy, 1);
    rst = 1'b0;

    // Drain length, with a spurious r_done inside it
    tick(20);
    spur_done = 1'b1; spur_iters = 7'h33;
    tick(1);
    spur_done = 1'b0;
    c = 21;
    while (busy === 1'b1 && c < 1000) begin
      tick(1);
      c++;
    end
    chk("drain_cycles", c, ITER + 5);
    chk("drain_no_write", wlog_addr.size(), 0);

    // Spurious r_done in IDLE
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(3);
    chk("idle_busy", busy, 0);
    chk("idle_wr_valid", wr_valid, 0);
    chk("idle_no_write", wlog_addr.size(), 0);
    chk("idle_no_start", start_count, 0);

    // Frame 1: iters = x+4y, ready always high; view_cx changed mid-frame
    view_cx = 15'sh1000; view_cy = 15'sh0800; view_zoom = 3'd2;
    seed = 0; lat_fixed = 3; enable = 1'b1;
    wait_writes(2, 200);
    view_cx = 15'sh2000;
    tick(1);
    chk("r_cx_held", r_cx, 32'sh1000);
    frames++;
    wait_frame(frames, 500);
    check_frame(0, 32'sh1000, 32'sh0800, 2);

    // Frame 2 picks up the new origin; stall the write port for 5 cycles
    rdy_dir = 1'b0;
    wait_start(20);
    chk("r_cx_new", r_cx, 32'sh2000);
    c = 0;
    while (wr_valid !== 1'b1 && c < 50) begin
      tick(1);
      c++;
    end
    a = int'(wr_addr);
    d = int'(wr_data);
    chk("stall_first_addr", a, 0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_wr_valid", wr_valid, 1);
      chk("stall_wr_addr", wr_addr, a);
      chk("stall_wr_data", wr_data, d);
      chk("stall_no_start", r_start, 0);
      spur_done = (k == 1); spur_iters = 7'h55;
      tick(1);
    end
    spur_done = 1'b0;
    chk("stall_no_write", wlog_addr.size(), 0);
    rdy_dir = 1'b1;
    frames++;
    wait_frame(frames, 500);
    check_frame(0, 32'sh2000, 32'sh0800, 2);

    // Frame 3: reset while waiting on pixel 3
    wait_writes(3, 200);
    wait_start(20);
    tick(1);
    rst = 1'b1;
    #1;
    chk("arst_r_start", r_start, 0);
    chk("arst_wr_valid", wr_valid, 0);
    chk("arst_busy", busy, 1);
    chk("arst_r_x", r_x, 0);
    chk("arst_r_cx", r_cx, 0);
    chk("arst_wr_addr", wr_addr, 0);
    tick(1);
    rst = 1'b0;
    clear_logs();
    sc = start_count;
    c = 0;
    while (r_start !== 1'b1 && c < 1000) begin
      tick(1);
      c++;
    end
    chk("arst_quiet_cycles", (c >= ITER + 4) ? 1 : 0, 1);
    chk("arst_no_early_start", start_count, sc);
    frames++;
    wait_frame(frames, 500);
    check_frame(0, 32'sh2000, 32'sh0800, 2);

    // Next frame: drop enable at pixel 5, frame still completes
    wait_writes(5, 200);
    enable = 1'b0;
    frames++;
    wait_frame(frames, 500);
    check_frame(0, 32'sh2000, 32'sh0800, 2);
    sc = start_count;
    tick(20);
    chk("stop_busy", busy, 0);
    chk("stop_no_start", start_count, sc);
    chk("stop_frames", fd_count, frames);

    // Randomized frames: random view, seed, latency and ready pattern
    lat_fixed = 0;
    rdy_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      ecx = 15'($urandom);
      ecy = 15'($urandom);
      ez  = 3'($urandom);
      view_cx = ecx; view_cy = ecy; view_zoom = ez;
      seed = int'($urandom_range(0, 127));
      enable = 1'b1;
      wait_start(20);
      enable = 1'b0;
      view_cx = 15'($urandom); view_cy = 15'($urandom); view_zoom = 3'($urandom);
      frames++;
      wait_frame(frames, 2000);
      check_frame(seed, int'(ecx), int'(ecy), int'(ez));
      tick(2);
    end
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
